id_decode_stage: RTL and testbench
==================================

# id_decode_stage

Instruction-decode stage of the 5-stage pipeline, directly upstream of the execute stage. Reads the 32×32 register file, sign-extends the immediate, decodes control, detects load-use hazards and precomputes the operand forwarding selects (`rsMux`/`rtMux`) consumed by execute. All results are held in the ID/EX pipeline register. The register file is written by the write-back stage through this block.

## Interface
Parameters:
- none. Widths are fixed: 32-bit data, 5-bit register index.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `instr`  in  32  instruction from the IF/ID register.
- `if_valid`  in  1  `instr` is a real instruction; when 0 it is treated as a NOP.
- `flush`  in  1  branch taken; the instruction in ID is discarded.
- `wb_we`  in  1  write-back enable.
- `wb_addr`  in  5  write-back register.
- `wb_data`  in  32  write-back data.
- `stall`  out  1  combinational; freezes PC and IF/ID this cycle.
- `RSd`, `RTd`  out  32  registered rs/rt register values.
- `emediato`  out  32  registered sign-extended `instr[15:0]`.
- `opcode`  out  6  registered `instr[31:26]`.
- `rsMux`, `rtMux`  out  2  registered forwarding selects: 00 register value, 01 EX/MEM result, 10 MEM/WB result.
- `aluSrc`, `regWrite`, `memRead`, `memWrite`, `memToReg`  out  1  registered control.
- `destReg`  out  5  registered destination register.

## Operation
- Decode of `instr`:
  - R-type (opcode 0x00): dest=rd, regWrite=1, uses rs and rt.
  - addi 0x08, slti 0x0A, andi 0x0C, ori 0x0D: dest=rt, regWrite=1, aluSrc=1, uses rs.
  - lw 0x23: dest=rt, regWrite=1, memRead=1, memToReg=1, aluSrc=1, uses rs.
  - sw 0x2B: memWrite=1, aluSrc=1, uses rs and rt.
  - beq 0x04: uses rs and rt, no write.
  - Any other opcode, or `if_valid`=0: bubble.
- A bubble loads ID/EX with all control bits, `destReg`, `rsMux` and `rtMux` at 0. Data fields are don't-care but are driven to 0.
- dest=0 forces regWrite=0.
- Register file:
  - r0 always reads 0 and ignores writes.
  - Reset clears all 32 entries.
  - Read during a same-cycle write to the same nonzero register returns `wb_data` (write-through).
- In-flight tracking: the block keeps an EX/MEM mirror holding the previous ID/EX `regWrite`/`destReg`. The mirror updates every cycle, including during stall.
- Forwarding select for a used source register s ≠ 0:
  - 01 if ID/EX has regWrite and destReg==s.
  - else 10 if the EX/MEM mirror has regWrite and dest==s.
  - else 00.
  - An unused or zero source selects 00.
- Load-use stall: `stall`=1 when ID/EX has memRead, destReg≠0, and destReg equals a used source of a valid decoded instruction. On stall, ID/EX takes a bubble and the instruction stays in IF/ID.
- After one stall the load sits in the EX/MEM mirror, so the retried instruction gets select 10.
- `flush`:
  - ID/EX takes a bubble.
  - `stall` is forced to 0.
  - Flush has priority over stall.

## Timing
- Reset (async assert, any time including mid-operation): every registered output goes to 0, the EX/MEM mirror clears, and the register file clears. `stall` reads 0 while in reset. Release is synchronous to `clk`.
- Latency: `instr` present at edge N appears on the ID/EX outputs after edge N.
- A write at edge N is visible to a read in the same cycle N via write-through, and from the array after edge N.
- `stall` depends only on the current `instr`, `if_valid`, `flush` and the ID/EX state. It has no dependence on `wb_*`.
- A load-use hazard stalls for exactly 1 cycle. Back-to-back hazards stall independently, 1 cycle each.

## Test plan
- Reset mid-stream with r5=0x1234 and a valid ID/EX -> all outputs 0 immediately; r5 reads 0 after release.
- Write `wb_addr`=3, `wb_data`=0xDEADBEEF while decoding `add r4,r3,r0` -> `RSd`=0xDEADBEEF next cycle. Write to r0 -> r0 still reads 0.
- `add r1,r2,r3`; `sub r4,r1,r1`; `or r5,r1,r6` -> `sub` gets `rsMux`=`rtMux`=01. `or` gets `rsMux`=10, `rtMux`=00.
- `lw r2,4(r1)`; `add r3,r2,r2` -> `stall`=1 for 1 cycle with a bubble in ID/EX. `add` then issues with `rsMux`=`rtMux`=10.
- `flush` asserted together with a load-use hazard -> `stall`=0 and ID/EX is a bubble.
- `addi r7,r0,-1` -> `emediato`=0xFFFFFFFF, `aluSrc`=1, `destReg`=7. An unknown opcode 0x3F -> bubble.

Source files
------------

// File: rtl/id_decode_stage.sv
// id_decode_stage: ID stage with register file, decode, load-use stall, forwarding selects and ID/EX register
module id_decode_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        if_valid,
  input  logic        flush,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        stall,
  output logic [31:0] RSd,
  output logic [31:0] RTd,
  output logic [31:0] emediato,
  output logic [5:0]  opcode,
  output logic [1:0]  rsMux,
  output logic [1:0]  rtMux,
  output logic        aluSrc,
  output logic        regWrite,
  output logic        memRead,
  output logic        memWrite,
  output logic        memToReg,
  output logic [4:0]  destReg
);
  logic [31:0] rf_q [32];
  logic [31:0] rf_d [32];
  logic [31:0] rs_data_q, rs_data_d, rt_data_q, rt_data_d, imm_q, imm_d;
  logic [5:0]  opcode_q, opcode_d;
  logic [1:0]  rs_mux_q, rs_mux_d, rt_mux_q, rt_mux_d;
  logic        alu_src_q, alu_src_d, reg_write_q, reg_write_d;
  logic        mem_read_q, mem_read_d, mem_write_q, mem_write_d, mem_to_reg_q, mem_to_reg_d;
  logic [4:0]  dest_reg_q, dest_reg_d;
  logic        mir_we_q, mir_we_d;
  logic [4:0]  mir_dest_q, mir_dest_d;
  logic [5:0]  op;
  logic [4:0]  rs, rt, rd, dest;
  logic        is_r, is_i, is_lw, is_sw, is_beq, dec_ok, use_rs, use_rt, hazard, bubble;
  logic [31:0] rs_val, rt_val;
  logic [1:0]  rs_sel, rt_sel;
  assign op     = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign is_r   = op == 6'h00;
  assign is_i   = op == 6'h08 || op == 6'h0A || op == 6'h0C || op == 6'h0D;
  assign is_lw  = op == 6'h23;
  assign is_sw  = op == 6'h2B;
  assign is_beq = op == 6'h04;
  assign dec_ok = if_valid && (is_r || is_i || is_lw || is_sw || is_beq);
  assign use_rs = dec_ok;
  assign use_rt = dec_ok && (is_r || is_sw || is_beq);
  assign dest   = is_r ? rd : (is_i || is_lw) ? rt : 5'd0;
  // Only the load sitting in ID/EX can hazard; one cycle later it is in the mirror and forwards via 10.
  assign hazard = mem_read_q && dest_reg_q != 5'd0 &&
                  ((use_rs && rs == dest_reg_q) || (use_rt && rt == dest_reg_q));
  assign stall  = !flush && hazard;
  assign bubble = flush || hazard || !dec_ok;
  // Write-through so a same-cycle write-back is seen without waiting for the array update.
  assign rs_val = rs == 5'd0 ? 32'd0 : (wb_we && wb_addr == rs) ? wb_data : rf_q[rs];
  assign rt_val = rt == 5'd0 ? 32'd0 : (wb_we && wb_addr == rt) ? wb_data : rf_q[rt];
  assign rs_sel = (!use_rs || rs == 5'd0) ? 2'b00 : (reg_write_q && dest_reg_q == rs) ? 2'b01 :
                  (mir_we_q && mir_dest_q == rs) ? 2'b10 : 2'b00;
  assign rt_sel = (!use_rt || rt == 5'd0) ? 2'b00 : (reg_write_q && dest_reg_q == rt) ? 2'b01 :
                  (mir_we_q && mir_dest_q == rt) ? 2'b10 : 2'b00;
  always_comb begin
    rf_d = rf_q;
    if (wb_we && wb_addr != 5'd0) rf_d[wb_addr] = wb_data;
  end
  always_comb begin
    rs_data_d    = bubble ? 32'd0 : rs_val;
    rt_data_d    = bubble ? 32'd0 : rt_val;
    imm_d        = bubble ? 32'd0 : {{16{instr[15]}}, instr[15:0]};
    opcode_d     = bubble ? 6'd0 : op;
    rs_mux_d     = bubble ? 2'b00 : rs_sel;
    rt_mux_d     = bubble ? 2'b00 : rt_sel;
    alu_src_d    = !bubble && (is_i || is_lw || is_sw);
    reg_write_d  = !bubble && (is_r || is_i || is_lw) && dest != 5'd0;
    mem_read_d   = !bubble && is_lw;
    mem_write_d  = !bubble && is_sw;
    mem_to_reg_d = !bubble && is_lw;
    dest_reg_d   = bubble ? 5'd0 : dest;
    mir_we_d     = reg_write_q;
    mir_dest_d   = dest_reg_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
      rs_data_q    <= '0;
      rt_data_q    <= '0;
      imm_q        <= '0;
      opcode_q     <= '0;
      rs_mux_q     <= '0;
      rt_mux_q     <= '0;
      alu_src_q    <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      dest_reg_q   <= '0;
      mir_we_q     <= 1'b0;
      mir_dest_q   <= '0;
    end else begin
      for (int i = 0; i < 32; i++) rf_q[i] <= rf_d[i];
      rs_data_q    <= rs_data_d;
      rt_data_q    <= rt_data_d;
      imm_q        <= imm_d;
      opcode_q     <= opcode_d;
      rs_mux_q     <= rs_mux_d;
      rt_mux_q     <= rt_mux_d;
      alu_src_q    <= alu_src_d;
      reg_write_q  <= reg_write_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      dest_reg_q   <= dest_reg_d;
      mir_we_q     <= mir_we_d;
      mir_dest_q   <= mir_dest_d;
    end
  end
  assign RSd      = rs_data_q;
  assign RTd      = rt_data_q;
  assign emediato = imm_q;
  assign opcode   = opcode_q;
  assign rsMux    = rs_mux_q;
  assign rtMux    = rt_mux_q;
  assign aluSrc   = alu_src_q;
  assign regWrite = reg_write_q;
  assign memRead  = mem_read_q;
  assign memWrite = mem_write_q;
  assign memToReg = mem_to_reg_q;
  assign destReg  = dest_reg_q;
endmodule

// File: tb/tb_id_decode_stage.sv
// tb_id_decode_stage: scoreboard bench for id_decode_stage with directed vectors
module tb_id_decode_stage;
  typedef struct packed {
    logic [31:0] rsd, rtd, imm;
    logic [5:0]  op;
    logic [1:0]  rsm, rtm;
    logic        alu, rw, mr, mw, m2r;
    logic [4:0]  dest;
  } out_t;
  localparam logic [4:0] C_R = 5'b01000, C_I = 5'b11000, C_I0 = 5'b10000, C_LW = 5'b11101,
                         C_SW = 5'b10010, C_NONE = 5'b00000;
  logic clk = 1'b0, rst_n = 1'b0, if_valid = 1'b0, flush = 1'b0, wb_we = 1'b0;
  logic [31:0] instr = '0, wb_data = '0;
  logic [4:0] wb_addr = '0;
  logic stall, aluSrc, regWrite, memRead, memWrite, memToReg;
  logic [31:0] RSd, RTd, emediato;
  logic [5:0] opcode;
  logic [1:0] rsMux, rtMux;
  logic [4:0] destReg;
  int passed = 0, total = 0;
  logic sq[$];
  out_t oq[$];
  logic pend = 1'b0;
  id_decode_stage dut (.clk(clk), .rst_n(rst_n), .instr(instr), .if_valid(if_valid), .flush(flush),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .stall(stall), .RSd(RSd), .RTd(RTd),
    .emediato(emediato), .opcode(opcode), .rsMux(rsMux), .rtMux(rtMux), .aluSrc(aluSrc),
    .regWrite(regWrite), .memRead(memRead), .memWrite(memWrite), .memToReg(memToReg), .destReg(destReg));
  always #5 clk = ~clk;
  function automatic logic [31:0] ri(input logic [4:0] s, input logic [4:0] t, input logic [4:0] d, input logic [5:0] fn);
    return {6'h00, s, t, d, 5'd0, fn};
  endfunction
  function automatic logic [31:0] ii(input logic [5:0] o, input logic [4:0] s, input logic [4:0] t, input logic [15:0] im);
    return {o, s, t, im};
  endfunction
  function automatic out_t mk(input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm, input logic [5:0] op,
                              input logic [1:0] rsm, input logic [1:0] rtm, input logic [4:0] c, input logic [4:0] dest);
    return {rsd, rtd, imm, op, rsm, rtm, c, dest};
  endfunction
  function automatic out_t act();
    return {RSd, RTd, emediato, opcode, rsMux, rtMux, aluSrc, regWrite, memRead, memWrite, memToReg, destReg};
  endfunction
  task automatic chk(input string name, input out_t a, input out_t e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %h expected %h", name, a, e);
  endtask
  task automatic step(input logic [31:0] in, input logic v, input logic fl, input logic we, input logic [4:0] wa,
                      input logic [31:0] wd, input logic es, input out_t eo);
    instr = in; if_valid = v; flush = fl; wb_we = we; wb_addr = wa; wb_data = wd;
    sq.push_back(es);
    oq.push_back(eo);
    @(posedge clk);
    #1;
  endtask
  initial forever begin
    @(negedge clk);
    if (pend) begin
      out_t e;
      e = oq.pop_front();
      chk("idex", act(), e);
      pend = 1'b0;
    end
    if (sq.size() > 0) begin
      logic s;
      s = sq.pop_front();
      chk("stall", out_t'(stall), out_t'(s));
      pend = 1'b1;
    end
  end
  initial begin
    repeat (2) @(negedge clk);
    chk("reset_out", act(), '0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    step(ri(3, 0, 4, 6'h20), 1, 0, 1, 3, 32'hDEADBEEF, 0, mk(32'hDEADBEEF, 0, 32'h2020, 0, 0, 0, C_R, 4));
    step(ri(0, 3, 5, 6'h20), 1, 0, 1, 0, 32'h55, 0, mk(0, 32'hDEADBEEF, 32'h2820, 0, 0, 0, C_R, 5));
    step(ri(0, 0, 6, 6'h20), 1, 0, 0, 0, 0, 0, mk(0, 0, 32'h3020, 0, 0, 0, C_R, 6));
    step(ri(2, 3, 1, 6'h20), 1, 0, 0, 0, 0, 0, mk(0, 32'hDEADBEEF, 32'h0820, 0, 0, 0, C_R, 1));
    step(ri(1, 1, 4, 6'h22), 1, 0, 0, 0, 0, 0, mk(0, 0, 32'h2022, 0, 2'b01, 2'b01, C_R, 4));
    step(ri(1, 6, 5, 6'h25), 1, 0, 0, 0, 0, 0, mk(0, 0, 32'h2825, 0, 2'b10, 2'b00, C_R, 5));
    step(ii(6'h23, 1, 2, 16'h4), 1, 0, 0, 0, 0, 0, mk(0, 0, 32'h4, 6'h23, 0, 0, C_LW, 2));
    step(ri(2, 2, 3, 6'h20), 1, 0, 0, 0, 0, 1, '0);
    step(ri(2, 2, 3, 6'h20), 1, 0, 0, 0, 0, 0, mk(0, 0, 32'h1820, 0, 2'b10, 2'b10, C_R, 3));
    step(ii(6'h23, 1, 2, 16'h4), 1, 0, 0, 0, 0, 0, mk(0, 0, 32'h4, 6'h23, 0, 0, C_LW, 2));
    step(ri(2, 2, 3, 6'h20), 1, 1, 0, 0, 0, 0, '0);
    step(ii(6'h08, 0, 7, 16'hFFFF), 1, 0, 0, 0, 0, 0, mk(0, 0, 32'hFFFFFFFF, 6'h08, 0, 0, C_I, 7));
    step(ii(6'h3F, 1, 2, 16'h1234), 1, 0, 0, 0, 0, 0, '0);
    step(ri(1, 2, 3, 6'h20), 0, 0, 0, 0, 0, 0, '0);
    step(ii(6'h08, 1, 0, 16'h5), 1, 0, 0, 0, 0, 0, mk(0, 0, 32'h5, 6'h08, 0, 0, C_I0, 0));
    step(ii(6'h2B, 1, 2, 16'h8), 1, 0, 1, 2, 32'hCAFE, 0, mk(0, 32'hCAFE, 32'h8, 6'h2B, 0, 0, C_SW, 0));
    step(ii(6'h04, 2, 5, 16'hFFFE), 1, 0, 1, 5, 32'h1234, 0, mk(32'hCAFE, 32'h1234, 32'hFFFFFFFE, 6'h04, 0, 0, C_NONE, 0));
    wb_we = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midreset_out", act(), '0);
    chk("midreset_stall", out_t'(stall), '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    step(ri(5, 2, 1, 6'h20), 1, 0, 0, 0, 0, 0, mk(0, 0, 32'h0820, 0, 0, 0, C_R, 1));
    step(ii(6'h23, 8, 9, 16'h0), 1, 0, 0, 0, 0, 0, mk(0, 0, 0, 6'h23, 0, 0, C_LW, 9));
    step(ii(6'h23, 9, 10, 16'h0), 1, 0, 0, 0, 0, 1, '0);
    step(ii(6'h23, 9, 10, 16'h0), 1, 0, 0, 0, 0, 0, mk(0, 0, 0, 6'h23, 2'b10, 0, C_LW, 10));
    step(ri(10, 0, 11, 6'h20), 1, 0, 0, 0, 0, 1, '0);
    step(ri(10, 0, 11, 6'h20), 1, 0, 0, 0, 0, 0, mk(0, 0, 32'h5820, 0, 2'b10, 0, C_R, 11));
    if_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    if (sq.size() != 0 || oq.size() != 0) begin
      total++;
      $display("FAIL drain: got %0d/%0d pending expected 0/0", sq.size(), oq.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
